// File: rtl/dmux_pkg.sv
// Shared defaults and helpers for the dmux_stream demultiplexer.
package dmux_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NCH   = 8;
  localparam int CNT_W     = 16;

  // Smallest r with 2**r >= n, kept at least 1 so a select port always exists.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmux_slot.sv
// Single-channel 1-entry holding register: load wins over drain so a full
// slot can be emptied and refilled on the same edge.
module dmux_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_drain,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full
);

  logic [WIDTH-1:0] r_data;
  logic             r_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/dmux_stream.sv
// Registered 1-to-NCH valid/ready stream demultiplexer with per-channel slots.
// Optional broadcast routing is enabled by defining DMUX_STREAM_BCAST_EN.
module dmux_stream
  import dmux_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NCH   = DEF_NCH,
  localparam int SELW  = clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      in_sel,
  input  logic                 in_valid,
`ifdef DMUX_STREAM_BCAST_EN
  input  logic                 in_bcast,
`endif
  output logic                 in_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic                 err_sel,
  output logic [CNT_W-1:0]     word_cnt
);

  logic [NCH-1:0]   w_hit;
  logic [NCH-1:0]   w_room;
  logic [NCH-1:0]   w_load;
  logic [NCH-1:0]   w_full;
  logic             w_sel_ok;
  logic             w_bcast;
  logic             w_acc;
  logic             r_err_sel;
  logic [CNT_W-1:0] r_word_cnt;

`ifdef DMUX_STREAM_BCAST_EN
  assign w_bcast = in_bcast;
`else
  assign w_bcast = 1'b0;
`endif

  assign w_sel_ok = (32'(in_sel) < 32'(NCH));
  assign w_room   = ~w_full | out_ready;

  // Out-of-range selects are always accepted so they cannot wedge the source.
  always_comb begin
    in_ready = 1'b1;
    if (w_bcast)       in_ready = &w_room;
    else if (w_sel_ok) in_ready = |(w_hit & w_room);
  end

  assign w_acc = in_valid & in_ready;

  for (genvar i = 0; i < NCH; i++) begin : g_slot
    assign w_hit[i]  = (in_sel == SELW'(i));
    assign w_load[i] = w_acc & (w_bcast | w_hit[i]);

    dmux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load[i]),
      .i_data (in_data),
      .i_drain(out_ready[i]),
      .o_data (out_data[i*WIDTH +: WIDTH]),
      .o_full (w_full[i])
    );
  end

  // Bookkeeping: counts delivered words, latches discarded bad selects.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_sel  <= 1'b0;
      r_word_cnt <= '0;
    end else if (w_acc) begin
      if (w_bcast || w_sel_ok) r_word_cnt <= r_word_cnt + 1'b1;
      else                     r_err_sel  <= 1'b1;
    end
  end

  assign out_valid = w_full;
  assign err_sel   = r_err_sel;
  assign word_cnt  = r_word_cnt;

endmodule

// File: doc/dmux_stream.md
Name: dmux_stream

Overview:
- Parametrised 1-to-NCH stream demultiplexer, the registered and handshaked successor to the combinational DMux/DMux4Way/DMux8Way gates.
- Routes one WIDTH-bit word per cycle from a single valid/ready source to one of NCH channels, selected by in_sel.
- Each channel has its own 1-entry holding register, so one stalled consumer blocks only the words addressed to it.
- Sits between the CPU data path and the memory-mapped peripheral or output ports.

Parameters:
- WIDTH, 16, data word width (Hack word).
- NCH, 8, number of output channels (2..64, need not be a power of two).
- SELW, $clog2(NCH), select width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- in_data  input  WIDTH  word to route.
- in_sel  input  SELW  target channel index.
- in_valid  input  1  source offers a word.
- in_ready  output  1  block accepts the word this cycle.
- out_data  output  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  NCH  channel i holds a word.
- out_ready  input  NCH  consumer i takes the word.
- err_sel  output  1  sticky flag: an out-of-range select was accepted.
- word_cnt  output  16  count of words delivered into channels.

Behaviour:
- Reset: when rst_n=0 at a clock edge, all holding registers clear, out_valid=0, out_data=0, err_sel=0, word_cnt=0. Reset wins over every other event in that cycle; words in flight are discarded.
- Channel i state is full[i], which drives out_valid[i] directly, and data[i], which drives its out_data slice.
- in_ready is combinational:
  - in_sel < NCH: in_ready = ~full[in_sel] | out_ready[in_sel].
  - in_sel >= NCH: in_ready = 1.
- Accept = in_valid & in_ready.
- Per channel, each clock edge:
  - Accept addressed to i: data[i] <= in_data, full[i] <= 1. This covers simultaneous drain and refill, giving full throughput of 1 word/cycle/channel.
  - Otherwise, full[i] & out_ready[i]: full[i] <= 0. data[i] holds its last value.
- Latency: a word accepted at edge k has out_valid=1 after edge k. There is no combinational path from in_data to out_data.
- Out-of-range select (only possible when NCH is not a power of two):
  - Word is accepted and discarded.
  - err_sel <= 1; err_sel stays set until reset.
  - word_cnt is not incremented.
- word_cnt increments by 1 on each accept with a valid select and wraps 0xFFFF -> 0x0000.
- Protocol rules:
  - Upstream keeps in_data and in_sel stable while in_valid & ~in_ready.
  - The block never drops out_valid[i] before the handshake on channel i.
  - The block never changes data[i] while full[i] & ~out_ready[i].
- out_ready[j] has no effect on accepts addressed to channel i != j.

Optional Feature:
- Macro DMUX_STREAM_BCAST_EN.
- Defined:
  - Adds input port in_bcast (1 bit).
  - When in_bcast=1, in_sel is ignored and in_ready = AND over all i of (~full[i] | out_ready[i]).
  - On accept, every channel loads in_data and sets full; word_cnt increments by 1; err_sel is unaffected.
- Undefined: the in_bcast port does not exist and only single-channel routing is supported.

Decomposition:
- Shared package/header dmux_pkg holds:
  - default WIDTH and NCH;
  - the word_cnt width constant (16);
  - a clog2 function for SELW.
- One natural sub-module, dmux_slot: a single-channel holding register (data, full, load, drain) instantiated NCH times through generate.
- The top level holds select decode, in_ready logic, err_sel and word_cnt.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> out_valid=8'h00, every out_data slice 16'h0000, in_ready=1, err_sel=0, word_cnt=0.
- Route: in_sel=3, in_data=16'hBEEF, in_valid for 1 cycle, all out_ready=1 -> next cycle out_valid=8'h08 and slice3=16'hBEEF; following cycle out_valid=8'h00; word_cnt=1.
- Backpressure: out_ready[5]=0; send 16'h1111 then 16'h2222 to channel 5 -> second word sees in_ready=0 and slice5 holds 16'h1111. Raise out_ready[5] -> in_ready=1 in the same cycle, and slice5 becomes 16'h2222 next cycle. Channel 2 traffic meanwhile flows unblocked.
- Bad select: NCH=6, in_sel=7, in_valid=1 -> in_ready=1, out_valid unchanged, err_sel=1 stays set, word_cnt unchanged.
- Reset mid-operation: channels 0 and 4 full with out_ready=0, rst_n=0 for one edge -> out_valid=0, word_cnt=0, err_sel=0 at that edge.
- Broadcast (DMUX_STREAM_BCAST_EN): channel 2 full and stalled, in_bcast=1, in_data=16'h00A5 -> in_ready=0. Release out_ready[2] -> accept, then out_valid=8'hFF with all slices 16'h00A5, word_cnt +1.
